// File: rtl/alu_seq_pkg.sv
// Shared types and opcode definitions for the register-register ALU instruction sequencer.
package alu_seq_pkg;

  localparam int OPC_W = 5;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_DEC,
    S_T3,
    S_T4,
    S_T5,
    S_T5W,
    S_T6,
    S_DONE
  } state_t;

  localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'b00101;
  localparam logic [OPC_W-1:0] OP_SHRA = 5'b00110;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'b00111;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'b01000;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'b01001;
  localparam logic [OPC_W-1:0] OP_AND  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_OR   = 5'b01011;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;

  // Unary ops take their single operand from rb and skip the Y load
  function automatic logic is_unary(input logic [OPC_W-1:0] op);
    return (op == OP_NEG) || (op == OP_NOT);
  endfunction

  function automatic logic is_hilo(input logic [OPC_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

  function automatic logic is_legal_op(input logic [OPC_W-1:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
      OP_AND, OP_OR, OP_MUL, OP_DIV, OP_NEG, OP_NOT: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/reg_onehot_dec.sv
// Register index to one-hot select decoder; all-zero when disabled or index out of range.
module reg_onehot_dec #(
  parameter int REG_IDX_W = 4,
  parameter int REG_CNT   = 16
) (
  input  logic                 en,
  input  logic [REG_IDX_W-1:0] idx,
  output logic [REG_CNT-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < REG_CNT; i++) begin
      onehot[i] = en && (idx == REG_IDX_W'(i));
    end
  end

endmodule

// File: rtl/alu_instr_sequencer.sv
// Control-step sequencer for register-register ALU instructions on the shared-bus datapath:
// fetch T0-T2 with memory wait states, decode, then execute T3-T6 driven by the IR fields.
module alu_instr_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int REG_CNT   = 16,
  parameter int REG_IDX_W = 4,
  parameter int OP_W      = 5,
  parameter int WAIT_MAX  = 15
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               start,
  input  logic               run_mode,
  input  logic               step,
  input  logic               mem_ready,
  input  logic [DATA_W-1:0]  ir_q,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic               pc_out,
  output logic               mdr_out,
  output logic               zlo_out,
  output logic               zhi_out,
  output logic               mar_rd,
  output logic               mdr_rd,
  output logic               ir_rd,
  output logic               y_rd,
  output logic               pc_rd,
  output logic               zlo_rd,
  output logic               zhi_rd,
  output logic               hi_rd,
  output logic               lo_rd,
  output logic               inc_pc,
  output logic               read,
  output logic [OP_W-1:0]    op_sel,
  output logic [REG_CNT-1:0] r_rd,
  output logic [REG_CNT-1:0] r_wrt
);

  localparam int CNT_W     = $clog2(WAIT_MAX + 1);
  localparam int FIELD_LSB = DATA_W - OP_W - 3 * REG_IDX_W;

  state_t             state;
  logic [CNT_W-1:0]   wait_cnt;
  logic               adv;
  logic [OP_W-1:0]    op;
  logic [REG_IDX_W-1:0] ra, rb, rc;
  logic               unary, hilo, idx_bad, illegal;
  logic               wrt_en, rd_en;
  logic [REG_IDX_W-1:0] wrt_idx;
  logic               unused_ir_bits;

  assign adv = run_mode | step;
  assign op  = ir_q[DATA_W-1 -: OP_W];
  assign ra  = ir_q[DATA_W-OP_W-1 -: REG_IDX_W];
  assign rb  = ir_q[DATA_W-OP_W-REG_IDX_W-1 -: REG_IDX_W];
  assign rc  = ir_q[DATA_W-OP_W-2*REG_IDX_W-1 -: REG_IDX_W];
  assign unused_ir_bits = ^ir_q[FIELD_LSB-1:0];

  assign unary = is_unary(op);
  assign hilo  = is_hilo(op);

  // Index range check only exists when the register file is smaller than the field can address
  if (REG_CNT < (1 << REG_IDX_W)) begin : g_idx_chk
    assign idx_bad = (ra >= REG_IDX_W'(REG_CNT)) || (rb >= REG_IDX_W'(REG_CNT)) ||
                     (!unary && (rc >= REG_IDX_W'(REG_CNT)));
  end else begin : g_no_idx_chk
    assign idx_bad = 1'b0;
  end

  assign illegal = !is_legal_op(op) || idx_bad;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        S_IDLE: if (start) state <= S_T0;
        S_T0: if (adv) begin
          state    <= S_T1;
          wait_cnt <= '0;
        end
        // T1 is paced by memory, not by run/step; the counter never passes WAIT_MAX
        S_T1: begin
          if (mem_ready) begin
            state <= S_T2;
          end else if (wait_cnt == CNT_W'(WAIT_MAX)) begin
            state <= S_IDLE;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_T2: if (adv) state <= S_DEC;
        S_DEC: if (adv) begin
          if (illegal) begin
            state <= S_IDLE;
            err   <= 1'b1;
          end else begin
            state <= unary ? S_T4 : S_T3;
          end
        end
        S_T3:  if (adv) state <= S_T4;
        S_T4:  if (adv) state <= hilo ? S_T5W : S_T5;
        S_T5:  if (adv) state <= S_DONE;
        S_T5W: if (adv) state <= S_T6;
        S_T6:  if (adv) state <= S_DONE;
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    pc_out  = 1'b0;
    mdr_out = 1'b0;
    zlo_out = 1'b0;
    zhi_out = 1'b0;
    mar_rd  = 1'b0;
    mdr_rd  = 1'b0;
    ir_rd   = 1'b0;
    y_rd    = 1'b0;
    pc_rd   = 1'b0;
    zlo_rd  = 1'b0;
    zhi_rd  = 1'b0;
    hi_rd   = 1'b0;
    lo_rd   = 1'b0;
    inc_pc  = 1'b0;
    read    = 1'b0;
    op_sel  = '0;
    wrt_en  = 1'b0;
    rd_en   = 1'b0;
    wrt_idx = rc;
    case (state)
      S_T0: begin
        busy = 1'b1; pc_out = 1'b1; mar_rd = 1'b1; inc_pc = 1'b1; zlo_rd = 1'b1;
      end
      S_T1: begin
        busy = 1'b1; zlo_out = 1'b1; read = 1'b1; mdr_rd = 1'b1;
        pc_rd = (wait_cnt == '0);
      end
      S_T2:  begin busy = 1'b1; mdr_out = 1'b1; ir_rd = 1'b1; end
      S_DEC: busy = 1'b1;
      S_T3: begin
        busy = 1'b1; y_rd = 1'b1; wrt_en = 1'b1; wrt_idx = rb;
      end
      S_T4: begin
        busy = 1'b1; op_sel = op; zlo_rd = 1'b1; zhi_rd = hilo;
        wrt_en = 1'b1; wrt_idx = unary ? rb : rc;
      end
      S_T5:  begin busy = 1'b1; zlo_out = 1'b1; rd_en = 1'b1; end
      S_T5W: begin busy = 1'b1; zlo_out = 1'b1; lo_rd = 1'b1; end
      S_T6:  begin busy = 1'b1; zhi_out = 1'b1; hi_rd = 1'b1; end
      S_DONE: done = 1'b1;
      default: ;
    endcase
  end

  reg_onehot_dec #(.REG_IDX_W(REG_IDX_W), .REG_CNT(REG_CNT)) u_rd_dec (
    .en     (rd_en),
    .idx    (ra),
    .onehot (r_rd)
  );

  reg_onehot_dec #(.REG_IDX_W(REG_IDX_W), .REG_CNT(REG_CNT)) u_wrt_dec (
    .en     (wrt_en),
    .idx    (wrt_idx),
    .onehot (r_wrt)
  );

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Scoreboard bench: stimulus plans each instruction's control steps and queues the expected
// per-cycle control word; a monitor compares the DUT whenever it presents activity.
module tb_alu_instr_sequencer;

  localparam int WAIT_MAX = 15;

  typedef struct packed {
    logic busy, done, err, pc_out, mdr_out, zlo_out, zhi_out, mar_rd, mdr_rd, ir_rd;
    logic y_rd, pc_rd, zlo_rd, zhi_rd, hi_rd, lo_rd, inc_pc, read;
    logic [4:0]  op_sel;
    logic [15:0] r_rd;
    logic [15:0] r_wrt;
  } ctl_t;

  logic        clk = 1'b0;
  logic        clr, start, run_mode, step, mem_ready;
  logic [31:0] ir_q;
  logic        busy, done, err, pc_out, mdr_out, zlo_out, zhi_out;
  logic        mar_rd, mdr_rd, ir_rd, y_rd, pc_rd, zlo_rd, zhi_rd, hi_rd, lo_rd, inc_pc, read;
  logic [4:0]  op_sel;
  logic [15:0] r_rd, r_wrt;
  ctl_t        act;

  ctl_t  expQ[$];
  string nameQ[$];
  int    compared = 0;
  int    mismatched = 0;
  bit    monEn = 1'b0;
  bit    finished = 1'b0;

  int legalOps[13] = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18};

  alu_instr_sequencer dut (
    .clk(clk), .clr(clr), .start(start), .run_mode(run_mode), .step(step),
    .mem_ready(mem_ready), .ir_q(ir_q), .busy(busy), .done(done), .err(err),
    .pc_out(pc_out), .mdr_out(mdr_out), .zlo_out(zlo_out), .zhi_out(zhi_out),
    .mar_rd(mar_rd), .mdr_rd(mdr_rd), .ir_rd(ir_rd), .y_rd(y_rd), .pc_rd(pc_rd),
    .zlo_rd(zlo_rd), .zhi_rd(zhi_rd), .hi_rd(hi_rd), .lo_rd(lo_rd),
    .inc_pc(inc_pc), .read(read), .op_sel(op_sel), .r_rd(r_rd), .r_wrt(r_wrt)
  );

  always #5 clk = ~clk;

  assign act = {busy, done, err, pc_out, mdr_out, zlo_out, zhi_out, mar_rd, mdr_rd, ir_rd,
                y_rd, pc_rd, zlo_rd, zhi_rd, hi_rd, lo_rd, inc_pc, read, op_sel, r_rd, r_wrt};

  task automatic checkOutput(input string nm, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Monitor: consumes one expected word per cycle in which activity is expected or seen
  always @(negedge clk) begin
    if (monEn && clr) begin
      if (expQ.size() > 0) begin
        ctl_t  e;
        string n;
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(n, 64'(act), 64'(e));
      end else if (busy || done || err) begin
        checkOutput("unexpectedOutput", 64'(act), 64'd0);
      end
    end
  end

  task automatic doCycle(input ctl_t w, input string nm, input logic stepIn, input logic memIn,
                         input bit noise);
    @(posedge clk);
    #1;
    step      = stepIn;
    mem_ready = memIn;
    start     = noise ? ($urandom_range(0, 3) == 0) : 1'b0;
    expQ.push_back(w);
    nameQ.push_back(nm);
  endtask

  // A run/step-paced control step: optional frozen cycles in step mode, then the advancing cycle
  task automatic advStep(input ctl_t w, input string nm, input bit run);
    int holds;
    holds = run ? 0 : int'($urandom_range(0, 2));
    repeat (holds) doCycle(w, nm, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
    doCycle(w, nm, !run, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      step  = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [31:0] ir, input bit run, input int waits);
    int   op, ra, rb, rc, n;
    bit   legal, unary, hilo;
    ctl_t w, errW, doneW;
    op = int'(ir[31:27]);
    ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);
    rc = int'(ir[18:15]);
    legal = 1'b0;
    foreach (legalOps[i]) if (legalOps[i] == op) legal = 1'b1;
    unary = (op == 17) || (op == 18);
    hilo  = (op == 15) || (op == 16);
    errW  = '0; errW.err = 1'b1;
    doneW = '0; doneW.done = 1'b1;

    @(posedge clk);
    #1;
    ir_q = ir; run_mode = run; start = 1'b1; step = 1'b0; mem_ready = 1'b0;

    w = '0; w.busy = 1; w.pc_out = 1; w.mar_rd = 1; w.inc_pc = 1; w.zlo_rd = 1;
    advStep(w, "T0", run);

    w = '0; w.busy = 1; w.zlo_out = 1; w.read = 1; w.mdr_rd = 1;
    n = (waits > WAIT_MAX) ? WAIT_MAX + 1 : waits;
    for (int i = 0; i < n; i++) begin
      w.pc_rd = (i == 0);
      doCycle(w, "T1wait", 1'b0, 1'b0, 1'b1);
    end
    if (waits > WAIT_MAX) begin
      doCycle(errW, "timeoutErr", 1'b0, 1'b0, 1'b0);
      return;
    end
    w.pc_rd = (waits == 0);
    doCycle(w, "T1ready", 1'b0, 1'b1, 1'b1);

    w = '0; w.busy = 1; w.mdr_out = 1; w.ir_rd = 1;
    advStep(w, "T2", run);
    w = '0; w.busy = 1;
    advStep(w, "DEC", run);
    if (!legal) begin
      doCycle(errW, "illegalErr", 1'b0, 1'b0, 1'b0);
      return;
    end
    if (!unary) begin
      w = '0; w.busy = 1; w.y_rd = 1; w.r_wrt = 16'(1 << rb);
      advStep(w, "T3", run);
    end
    w = '0; w.busy = 1; w.op_sel = 5'(op); w.zlo_rd = 1; w.zhi_rd = hilo;
    w.r_wrt = 16'(1 << (unary ? rb : rc));
    advStep(w, "T4", run);
    if (hilo) begin
      w = '0; w.busy = 1; w.zlo_out = 1; w.lo_rd = 1;
      advStep(w, "T5W", run);
      w = '0; w.busy = 1; w.zhi_out = 1; w.hi_rd = 1;
      advStep(w, "T6", run);
    end else begin
      w = '0; w.busy = 1; w.zlo_out = 1; w.r_rd = 16'(1 << ra);
      advStep(w, "T5", run);
    end
    doCycle(doneW, "DONE", 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resetMidT4();
    bit found;
    monEn = 1'b0;
    @(posedge clk);
    #1;
    ir_q = 32'h2A2B8000; run_mode = 1'b1; mem_ready = 1'b1; step = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (op_sel != 5'd0) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    checkOutput("reachT4", 64'(found), 64'd1);
    #2;
    clr = 1'b0;
    #1;
    checkOutput("resetMidT4Outputs", 64'(act), 64'd0);
    start = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("resetWinsOverStart", 64'(act), 64'd0);
    clr = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idleAfterRelease", 64'(act), 64'd0);
    monEn = 1'b1;
  endtask

  initial begin
    logic [31:0] ir;
    int          op, waits;
    clr = 1'b0; start = 1'b0; run_mode = 1'b0; step = 1'b0; mem_ready = 1'b0; ir_q = '0;
    #12;
    checkOutput("resetState", 64'(act), 64'd0);
    @(posedge clk);
    #1;
    clr = 1'b1;
    monEn = 1'b1;

    $display("[TB] directed instructions");
    applyStimulus(32'h2A2B8000, 1'b1, 0);
    idleCycles(2);
    applyStimulus(32'h7A2B8000, 1'b1, 0);
    idleCycles(2);
    applyStimulus(32'h8A280000, 1'b1, 0);
    idleCycles(2);
    applyStimulus(32'h2A2B8000, 1'b1, 3);
    idleCycles(2);
    applyStimulus(32'h2A2B8000, 1'b1, 99);
    idleCycles(2);
    applyStimulus(32'h2A2B8000, 1'b0, 2);
    idleCycles(2);
    applyStimulus(32'hF8000000, 1'b0, 0);
    idleCycles(2);

    $display("[TB] reset during execute");
    resetMidT4();

    $display("[TB] randomized instructions");
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) != 0) op = legalOps[$urandom_range(0, 12)];
      else op = int'($urandom_range(0, 31));
      ir = $urandom;
      ir[31:27] = 5'(op);
      waits = ($urandom_range(0, 15) == 0) ? 20 : int'($urandom_range(0, 4));
      applyStimulus(ir, 1'($urandom_range(0, 1)), waits);
      idleCycles(int'($urandom_range(1, 3)));
    end

    idleCycles(3);
    checkOutput("queueDrained", 64'(expQ.size()), 64'd0);
    finished = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    if (!finished) begin
      finished = 1'b1;
      compared++;
      mismatched++;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  end

endmodule
